bc_col_acc: RTL and testbench

Bit-plane accumulator sitting directly downstream of the compressor column array in the BC-MAC datapath. Each beat it takes the array's redundant (sum, carry) vectors for one activation bit-plane, resolves them with a carry-propagate add, and folds the result into a running accumulator MSB-plane-first (Horner: acc = 2·acc + beat). After NBITS beats it emits one dot-product result through a one-entry output buffer with valid/ready handshake.

---
 rtl/bc_col_acc.sv | 84 ++++++++
 tb/tb_bc_col_acc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bc_col_acc.sv
// bc_col_acc: resolves compressor (sum, carry) per bit-plane and Horner-accumulates NBITS planes MSB-first.
// Optional feature macro BC_SIGNED_MSB_EN: plane 0 carries negative weight (two's-complement activations).
module bc_col_acc #(
    parameter int unsigned W     = 8,
    parameter int unsigned NBITS = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sum,
    input  logic [W-1:0]     carry,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);
    localparam int unsigned V_W   = W + 2;
    localparam int unsigned CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(NBITS - 2);

    typedef enum logic {ST_ACC, ST_LAST} state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [ACC_W-1:0] acc;
    logic [V_W-1:0]   beat_v;
    logic [ACC_W-1:0] acc_next;
    logic             take;

    // Carry-propagate resolve of the redundant pair; carry has weight 2.
    assign beat_v = V_W'(sum) + (V_W'(carry) << 1);

    // A final beat with a full, unconsumed buffer must wait; all other beats go straight in.
    assign in_ready = !(state == ST_LAST && out_valid && !out_ready);
    assign take     = in_valid && in_ready;

    always_comb begin
        acc_next = (acc << 1) + ACC_W'(beat_v);
        if (beat_cnt == '0) begin
`ifdef BC_SIGNED_MSB_EN
            acc_next = ACC_W'(0) - ACC_W'(beat_v);
`else
            acc_next = ACC_W'(beat_v);
`endif
        end
    end

    // state tracks beat_cnt == NBITS-1 so in_ready decodes from a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACC;
            beat_cnt  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (flush) begin
                state    <= ST_ACC;
                beat_cnt <= '0;
                acc      <= '0;
            end else if (take) begin
                if (state == ST_LAST) begin
                    // Push wins over a same-cycle pop so no result is lost.
                    out_data  <= acc_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    beat_cnt  <= '0;
                    state     <= ST_ACC;
                end else begin
                    acc      <= acc_next;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (beat_cnt == PRE_LAST) begin
                        state <= ST_LAST;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bc_col_acc.sv
// tb_bc_col_acc: directed + random frames against a plain-arithmetic dot-product model.
// Honours BC_SIGNED_MSB_EN the same way as the design build.
module tb_bc_col_acc;
    localparam int unsigned W     = 8;
    localparam int unsigned NBITS = 4;
    localparam int unsigned ACC_W = 24;

    typedef logic [W-1:0] vec_t [NBITS];

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     sum;
    logic [W-1:0]     carry;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    bc_col_acc #(.W(W), .NBITS(NBITS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .carry(carry), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

`ifdef BC_SIGNED_MSB_EN
    localparam logic [ACC_W-1:0] DIRECTED_EXP = 24'hFFFFEC;
`else
    localparam logic [ACC_W-1:0] DIRECTED_EXP = 24'd28;
`endif

    task automatic chk(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Dot product of plane values with binary weights, MSB plane first.
    function automatic logic [ACC_W-1:0] model(input vec_t s, input vec_t c);
        longint r = 0;
        for (int i = 0; i < NBITS; i++) begin
            longint wgt = longint'(1) << (NBITS - 1 - i);
            longint v   = longint'(s[i]) + 2 * longint'(c[i]);
`ifdef BC_SIGNED_MSB_EN
            if (i == 0) wgt = -wgt;
`endif
            r += wgt * v;
        end
        return ACC_W'(r);
    endfunction

    task automatic gen(output vec_t s, output vec_t c);
        for (int i = 0; i < NBITS; i++) begin
            s[i] = W'($urandom);
            c[i] = W'($urandom);
        end
    endtask

    // One accepted beat: drive, clock, then release with junk data.
    task automatic beat(input logic [W-1:0] s, input logic [W-1:0] c);
        in_valid = 1'b1;
        sum      = s;
        carry    = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sum      = W'($urandom);
        carry    = W'($urandom);
    endtask

    task automatic frame(input vec_t s, input vec_t c);
        for (int i = 0; i < NBITS; i++) beat(s[i], c[i]);
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t s, c, s2, c2, ds, dc;
        logic [ACC_W-1:0] exp_a, exp_b;

        rst = 1'b1; in_valid = 1'b0; sum = '0; carry = '0; flush = 1'b0; out_ready = 1'b1;
        ds = '{8'd1, 8'd0, 8'd1, 8'd0};
        dc = '{8'd1, 8'd0, 8'd0, 8'd1};
        #12;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk ("rst_out_data",  out_data, '0);
        chk1("rst_in_ready",  in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // Directed frame v = 3,0,1,2 back-to-back, checking latency.
        for (int i = 0; i < NBITS - 1; i++) beat(ds[i], dc[i]);
        chk1("lat_before_final", out_valid, 1'b0);
        beat(ds[NBITS-1], dc[NBITS-1]);
        chk1("lat_out_valid", out_valid, 1'b1);
        chk ("directed_data", out_data, DIRECTED_EXP);
        idle();
        chk1("directed_popped", out_valid, 1'b0);

        // Random back-to-back frames with out_ready high.
        for (int f = 0; f < 6; f++) begin
            gen(s, c);
            frame(s, c);
            chk1($sformatf("rand%0d_valid", f), out_valid, 1'b1);
            chk ($sformatf("rand%0d_data", f), out_data, model(s, c));
        end
        idle();
        chk1("rand_drained", out_valid, 1'b0);

        // Maximum input on every plane.
        for (int i = 0; i < NBITS; i++) begin s[i] = 8'hFF; c[i] = 8'hFF; end
        frame(s, c);
        chk("max_data", out_data, model(s, c));
        idle();

        // Backpressure: second frame overlaps a held result, final beat stalls.
        out_ready = 1'b0;
        gen(s, c);
        exp_a = model(s, c);
        frame(s, c);
        chk1("bp_a_valid", out_valid, 1'b1);
        chk ("bp_a_data", out_data, exp_a);
        gen(s2, c2);
        exp_b = model(s2, c2);
        for (int i = 0; i < NBITS - 1; i++) begin
            chk1($sformatf("bp_rdy%0d", i), in_ready, 1'b1);
            beat(s2[i], c2[i]);
            chk($sformatf("bp_hold%0d", i), out_data, exp_a);
        end
        in_valid = 1'b1; sum = s2[NBITS-1]; carry = c2[NBITS-1];
        #1;
        chk1("bp_stall_rdy", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1($sformatf("bp_stall_rdy%0d", k), in_ready, 1'b0);
            chk ($sformatf("bp_stall_data%0d", k), out_data, exp_a);
        end
        // Pop and final push land on the same edge.
        out_ready = 1'b1;
        #1;
        chk1("sim_rdy", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("sim_valid", out_valid, 1'b1);
        chk ("sim_data", out_data, exp_b);
        idle();
        chk1("sim_no_dup", out_valid, 1'b0);

        // Flush mid-frame with a held result, then a clean directed frame.
        out_ready = 1'b0;
        gen(s, c);
        exp_a = model(s, c);
        frame(s, c);
        beat(W'($urandom), W'($urandom));
        beat(W'($urandom), W'($urandom));
        flush = 1'b1; in_valid = 1'b1; sum = W'($urandom); carry = W'($urandom);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_keep_valid", out_valid, 1'b1);
        chk ("flush_keep_data", out_data, exp_a);
        out_ready = 1'b1;
        idle();
        chk1("flush_popped", out_valid, 1'b0);
        frame(ds, dc);
        chk1("flush_frame_valid", out_valid, 1'b1);
        chk ("flush_frame_data", out_data, DIRECTED_EXP);
        idle();

        // Asynchronous reset mid-frame while a result is held.
        out_ready = 1'b0;
        gen(s, c);
        frame(s, c);
        for (int i = 0; i < NBITS - 1; i++) beat(W'($urandom), W'($urandom));
        chk1("pre_rst_rdy", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk ("arst_out_data", out_data, '0);
        chk1("arst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        gen(s, c);
        frame(s, c);
        chk1("post_rst_valid", out_valid, 1'b1);
        chk ("post_rst_data", out_data, model(s, c));
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
